// File: rtl/led_blink_array.sv
// led_blink_array: shared-prescaler multi-channel LED generator with OFF/ON/BLINK/ONESHOT modes.
module led_blink_array #(
  parameter int         CLK_FREQ_HZ = 50_000_000,
  parameter int         TICK_HZ     = 1000,
  parameter int         N_LED       = 4,
  parameter int         PERIOD_W    = 16,
  parameter int         RST_PERIOD  = 500,
  parameter logic [1:0] RST_MODE    = 2'd2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [3:0]          wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [PERIOD_W-1:0] wr_period,
  output logic [N_LED-1:0]    led,
  output logic [N_LED-1:0]    busy,
  output logic                tick
);
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_ONE = 2'd3;
  localparam logic [1:0] RMODE = (RST_MODE == M_ONE) ? M_OFF : RST_MODE;
  logic [PW-1:0] pcnt;
  logic [PERIOD_W-1:0] wp;
  assign wp = (wr_period == '0) ? PERIOD_W'(1) : wr_period;
  // tick is registered one count early so it is high exactly while pcnt == DIV-1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= (pcnt == PW'(DIV - 1)) ? '0 : pcnt + 1'b1;
      tick <= pcnt == PW'(DIV - 2);
    end
  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    logic [1:0] mode;
    logic [PERIOD_W-1:0] period, tcnt;
    logic led_q, hit, due;
    assign hit = wr_en && wr_ch == 4'(i);
    assign due = tcnt == period - 1'b1;
    assign led[i] = led_q;
    assign busy[i] = mode == M_ONE;
    // a write wins over a coincident tick for this channel only
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        mode   <= RMODE;
        period <= PERIOD_W'(RST_PERIOD);
        tcnt   <= '0;
        led_q  <= 1'b0;
      end else if (hit) begin
        mode   <= wr_mode;
        period <= wp;
        tcnt   <= '0;
        led_q  <= wr_mode != M_OFF;
      end else if (mode == M_OFF || mode == M_ON) begin
        tcnt  <= '0;
        led_q <= mode == M_ON;
      end else if (tick) begin
        tcnt <= due ? '0 : tcnt + 1'b1;
        if (due && mode == M_BLINK) led_q <= ~led_q;
        if (due && mode == M_ONE) begin
          led_q <= 1'b0;
          mode  <= M_OFF;
        end
      end
  end
endmodule

// File: tb/tb_led_blink_array.sv
// tb_led_blink_array: directed checks of prescaler, blink, oneshot, collisions and reset.
module tb_led_blink_array;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, tick;
  logic [3:0] wr_ch = '0, led, busy;
  logic [1:0] wr_mode = '0;
  logic [15:0] wr_period = '0;
  int n_cmp = 0, n_bad = 0, e = 0;
  led_blink_array #(
    .CLK_FREQ_HZ(1000), .TICK_HZ(100), .N_LED(4), .PERIOD_W(16),
    .RST_PERIOD(3), .RST_MODE(2'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_period(wr_period), .led(led), .busy(busy), .tick(tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic goto(input int t);
    while (e < t) begin
      @(negedge clk);
      e++;
    end
  endtask
  task automatic wr(input logic [3:0] ch, input logic [1:0] m, input logic [15:0] p);
    wr_en = 1'b1;
    wr_ch = ch;
    wr_mode = m;
    wr_period = p;
    @(negedge clk);
    e++;
    wr_en = 1'b0;
  endtask
  task automatic default_blink(input string pfx);
    chk({pfx, "_led0"}, led, 4'h0);
    chk({pfx, "_busy0"}, busy, 4'h0);
    chk({pfx, "_tick0"}, tick, 1'b0);
    goto(8);  chk({pfx, "_tick8"}, tick, 1'b0);
    goto(9);  chk({pfx, "_tick9"}, tick, 1'b1);
    goto(10); chk({pfx, "_tick10"}, tick, 1'b0);
    goto(19); chk({pfx, "_tick19"}, tick, 1'b1);
    goto(29); chk({pfx, "_led29"}, led, 4'h0);
    goto(30); chk({pfx, "_led30"}, led, 4'hf);
    goto(59); chk({pfx, "_led59"}, led, 4'hf);
    goto(60); chk({pfx, "_led60"}, led, 4'h0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    default_blink("rst");
    goto(61); wr(4'd1, 2'd2, 16'd2);
    chk("blink_e62", led, 4'b0010);
    goto(79); chk("blink_e79", led, 4'b0010);
    goto(80); chk("blink_e80", led, 4'b0000);
    goto(90); chk("blink_e90", led, 4'b1101);
    goto(100); chk("blink_e100", led, 4'b1111);
    goto(119); chk("blink_e119", led, 4'b1111);
    goto(120); chk("blink_e120", led, 4'b0000);
    goto(121); wr(4'd2, 2'd3, 16'd4);
    chk("one_led122", led, 4'b0100);
    chk("one_busy122", busy, 4'b0100);
    goto(159); chk("one_led159", led, 4'b1111);
    chk("one_busy159", busy, 4'b0100);
    goto(160); chk("one_led160", led, 4'b1001);
    chk("one_busy160", busy, 4'b0000);
    goto(171); wr(4'd2, 2'd3, 16'd4);
    chk("rearm_busy172", busy, 4'b0100);
    goto(191); wr(4'd2, 2'd3, 16'd4);
    goto(210); chk("rearm_busy210", busy, 4'b0100);
    goto(229); chk("rearm_busy229", busy, 4'b0100);
    chk("rearm_led2_229", led[2], 1'b1);
    goto(230); chk("rearm_busy230", busy, 4'b0000);
    chk("rearm_led2_230", led[2], 1'b0);
    goto(239); chk("coll_tick239", tick, 1'b1);
    chk("coll_led3_239", led[3], 1'b1);
    wr(4'd0, 2'd1, 16'd9);
    chk("coll_led0_240", led[0], 1'b1);
    chk("coll_led3_240", led[3], 1'b0);
    goto(241); wr(4'd1, 2'd2, 16'd0);
    chk("p0_e242", led[1], 1'b1);
    goto(249); chk("p0_e249", led[1], 1'b1);
    goto(250); chk("p0_e250", led[1], 1'b0);
    goto(260); chk("p0_e260", led[1], 1'b1);
    goto(270); chk("p0_e270", led[1], 1'b0);
    goto(271); wr(4'd7, 2'd0, 16'd5);
    chk("ch7_led", led, 4'b1001);
    chk("ch7_busy", busy, 4'b0000);
    goto(300); chk("ch7_led3_300", led[3], 1'b0);
    goto(301); wr(4'd2, 2'd0, 16'd1);
    for (int k = 0; k < 50; k++) begin
      goto(310 + 10 * k);
      chk($sformatf("steady_on_%0d", k), led[0], 1'b1);
      chk($sformatf("steady_off_%0d", k), led[2], 1'b0);
    end
    goto(801); wr(4'd2, 2'd3, 16'd4);
    goto(809); chk("mid_busy", busy, 4'b0100);
    chk("mid_tick", tick, 1'b1);
    chk("mid_led2", led[2], 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("arst_led", led, 4'h0);
    chk("arst_busy", busy, 4'h0);
    chk("arst_tick", tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    default_blink("rel");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
